alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, two-stage pipelined ALU with a valid/ready handshake on both sides and a status-flag output. It is the sequential successor of our combinational 8-bit ALU. It keeps the same 6-bit MIPS funct opcode encoding, adds SLL/SLT/SLTU, and adds carry/overflow/zero/negative flags and an illegal-opcode indication. It sits between the operand source (register file or UART command decoder) and the result sink, and accepts one operation per cycle.

## Interface
- NB_BITS, 8: operand/result width; ≥ 4, power of two.
- NB_OPE, 6: opcode width; fixed encoding, must be 6.
- i_clock  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_valid  in  1  upstream holds a valid operation.
- o_ready  out  1  block accepts an operation this cycle.
- i_dato_a  in  NB_BITS  operand A.
- i_dato_b  in  NB_BITS  operand B; shift amount for shift ops.
- i_ope_sel  in  NB_OPE  opcode.
- o_valid  out  1  o_result/o_flags/o_err valid.
- i_ready  in  1  downstream accepts the result.
- o_result  out  NB_BITS  result.
- o_flags  out  4  {N, Z, C, V}.
- o_err  out  1  operation carried an unsupported opcode.

## Operation
- Opcodes: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 000000 SLL, 000010 SRL, 000011 SRA, 101010 SLT (signed), 101011 SLTU (unsigned).
- ADD/SUB use NB_BITS+1-bit internal arithmetic.
  - ADD: C = carry-out.
  - SUB: C = borrow, i.e. 1 when A < B unsigned.
  - V = signed overflow for ADD/SUB; 0 for all other ops. C is also 0 for all other ops.
- Shifts use B as an unsigned amount.
  - Amount ≥ NB_BITS: SLL/SRL give 0; SRA gives all bits equal to A's MSB.
- SLT/SLTU: result is 1 (zero-extended) when the compare is true, else 0.
- N = result MSB. Z = (result == 0). Both are computed for every op, including illegal ones.
- Illegal opcode: result 0, o_err = 1, flags {0,1,0,0}. The op still flows through the pipeline in order.
- Stage 1 (input register): captures A, B and opcode on the i_valid && o_ready handshake.
- Stage 2 (output register): captures the computed result, flags and err from stage 1.
- Pipeline control:
  - Stage 2 loads when it is empty or i_ready = 1.
  - Stage 1 advances when stage 2 loads.
  - o_ready = !s1_valid || s1_advance. The combinational path runs i_ready → o_ready; the bench must tolerate it.

## Timing
- Reset (i_reset = 0 at a rising edge): s1_valid = s2_valid = 0.
  - o_valid = 0, o_result = 0, o_flags = 0, o_err = 0.
  - o_ready = 1 in the first cycle after release.
- Reset mid-operation discards both stages without producing output. Inputs presented during reset are ignored.
- Latency: an op accepted at edge k is presented on o_valid after edge k+1 (readable at edge k+2) when i_ready = 1.
- Throughput: 1 op/cycle with i_ready held high.
- Backpressure: while o_valid && !i_ready, o_result/o_flags/o_err are held stable. Stage 1 may still fill once; o_ready then drops. No op is lost or duplicated.
- Simultaneous accept and drain in a full pipe: the stage 2 result leaves, stage 1 moves into stage 2, and the new op enters stage 1, all on the same edge.
- o_valid never depends combinationally on i_valid.

## Structure
- Include file alu_defs.vh holds:
  - opcode localparams (ALU_ADD … ALU_SLTU);
  - flag bit indices (FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0).
- Sub-module alu_core: purely combinational, parametrised by NB_BITS. Inputs: A, B, opcode. Outputs: result, flags, err. It sits between stage 1 and stage 2.
- alu_pipe contains only the two register stages and the handshake logic.

## Test plan
Values are for NB_BITS = 8.
- ADD A=0x7F, B=0x01, i_ready=1 → after 2 edges o_result=0x80, flags N=1 Z=0 C=0 V=1. ADD 0xFF+0x01 → 0x00, Z=1 C=1 V=0.
- SUB 0x00−0x01 → 0xFF, N=1 C=1 V=0. SUB 0x80−0x01 → 0x7F, V=1. SLT 0xFF,0x01 → 0x01; SLTU 0xFF,0x01 → 0x00.
- Shifts:
  - SRA 0x80 by 3 → 0xF0; SRA 0x80 by 9 → 0xFF.
  - SRL 0x80 by 9 → 0x00; SLL 0x01 by 7 → 0x80.
- Opcode 6'b111111 with A=0x55 → o_result=0x00, o_err=1, Z=1; the next legal op returns o_err=0.
- Stream 10 ADDs (A=i, B=1) with i_ready low for 3 cycles mid-stream:
  - o_ready drops after 2 ops are held;
  - outputs stay stable while stalled;
  - all 10 results 0x01…0x0A appear in order, with no gaps while i_ready = 1.
- Assert i_reset = 0 for 1 cycle with both stages full → o_valid=0 and all outputs 0 next cycle, o_ready=1, and no stale result ever appears.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the pipelined ALU: MIPS funct opcodes, flag layout
// and small helpers used by the datapath.
package alu_pipe_pkg;

   localparam int OPE_W    = 6;
   localparam int NB_FLAGS = 4;

   localparam logic [OPE_W-1:0] ALU_ADD  = 6'b100000;
   localparam logic [OPE_W-1:0] ALU_SUB  = 6'b100010;
   localparam logic [OPE_W-1:0] ALU_AND  = 6'b100100;
   localparam logic [OPE_W-1:0] ALU_OR   = 6'b100101;
   localparam logic [OPE_W-1:0] ALU_XOR  = 6'b100110;
   localparam logic [OPE_W-1:0] ALU_NOR  = 6'b100111;
   localparam logic [OPE_W-1:0] ALU_SLL  = 6'b000000;
   localparam logic [OPE_W-1:0] ALU_SRL  = 6'b000010;
   localparam logic [OPE_W-1:0] ALU_SRA  = 6'b000011;
   localparam logic [OPE_W-1:0] ALU_SLT  = 6'b101010;
   localparam logic [OPE_W-1:0] ALU_SLTU = 6'b101011;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      ARITH_NONE = 2'b00,
      ARITH_ADD  = 2'b01,
      ARITH_SUB  = 2'b10
   } arith_kind_e;

   function automatic logic [NB_FLAGS-1:0] pack_flags(
      input logic n,
      input logic z,
      input logic c,
      input logic v
   );
      logic [NB_FLAGS-1:0] f;
      f         = {NB_FLAGS{1'b0}};
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath between the two pipeline registers: computes
// result, {N,Z,C,V} flags and an unsupported-opcode indication.
module alu_core
   import alu_pipe_pkg::*;
#(
   parameter int NB_BITS = 8
) (
   input  logic [NB_BITS-1:0]  a,
   input  logic [NB_BITS-1:0]  b,
   input  logic [OPE_W-1:0]    ope_sel,
   output logic [NB_BITS-1:0]  result,
   output logic [NB_FLAGS-1:0] flags,
   output logic                err
);

   localparam int SHW = $clog2(NB_BITS);

   logic [NB_BITS:0]          sum_s;
   logic [NB_BITS:0]          diff_s;
   logic                      add_ovf_s;
   logic                      sub_ovf_s;
   logic                      shift_big_s;
   logic [SHW-1:0]            shamt_s;
   logic signed [NB_BITS-1:0] a_sgn_s;
   logic [NB_BITS-1:0]        sra_s;
   logic                      slt_s;
   logic                      sltu_s;
   logic [NB_BITS-1:0]        result_s;
   logic                      err_s;
   arith_kind_e               arith_s;

   assign sum_s  = {1'b0, a} + {1'b0, b};
   assign diff_s = {1'b0, a} - {1'b0, b};

   // Overflow: operands of the relevant sign agree but the result sign differs.
   assign add_ovf_s = (a[NB_BITS-1] == b[NB_BITS-1]) && (sum_s[NB_BITS-1]  != a[NB_BITS-1]);
   assign sub_ovf_s = (a[NB_BITS-1] != b[NB_BITS-1]) && (diff_s[NB_BITS-1] != a[NB_BITS-1]);

   // NB_BITS is a power of two, so any set bit above the low SHW bits means amount >= NB_BITS.
   assign shift_big_s = |b[NB_BITS-1:SHW];
   assign shamt_s     = b[SHW-1:0];
   assign a_sgn_s     = a;
   assign sra_s       = a_sgn_s >>> shamt_s;
   assign slt_s       = ($signed(a) < $signed(b));
   assign sltu_s      = (a < b);

   // Opcode decode and result selection.
   always_comb begin
      result_s = {NB_BITS{1'b0}};
      err_s    = 1'b0;
      arith_s  = ARITH_NONE;
      case (ope_sel)
         ALU_ADD: begin
            result_s = sum_s[NB_BITS-1:0];
            arith_s  = ARITH_ADD;
         end
         ALU_SUB: begin
            result_s = diff_s[NB_BITS-1:0];
            arith_s  = ARITH_SUB;
         end
         ALU_AND:  result_s = a & b;
         ALU_OR:   result_s = a | b;
         ALU_XOR:  result_s = a ^ b;
         ALU_NOR:  result_s = ~(a | b);
         ALU_SLL: begin
            if (shift_big_s) begin
               result_s = {NB_BITS{1'b0}};
            end else begin
               result_s = a << shamt_s;
            end
         end
         ALU_SRL: begin
            if (shift_big_s) begin
               result_s = {NB_BITS{1'b0}};
            end else begin
               result_s = a >> shamt_s;
            end
         end
         ALU_SRA: begin
            if (shift_big_s) begin
               result_s = {NB_BITS{a[NB_BITS-1]}};
            end else begin
               result_s = sra_s;
            end
         end
         ALU_SLT:  result_s = {{(NB_BITS-1){1'b0}}, slt_s};
         ALU_SLTU: result_s = {{(NB_BITS-1){1'b0}}, sltu_s};
         default: begin
            result_s = {NB_BITS{1'b0}};
            err_s    = 1'b1;
         end
      endcase
   end

   // Flag generation; C and V only carry meaning for ADD/SUB.
   always_comb begin
      flags = {NB_FLAGS{1'b0}};
      case (arith_s)
         ARITH_ADD: flags = pack_flags(result_s[NB_BITS-1], (result_s == {NB_BITS{1'b0}}),
                                       sum_s[NB_BITS], add_ovf_s);
         ARITH_SUB: flags = pack_flags(result_s[NB_BITS-1], (result_s == {NB_BITS{1'b0}}),
                                       diff_s[NB_BITS], sub_ovf_s);
         default:   flags = pack_flags(result_s[NB_BITS-1], (result_s == {NB_BITS{1'b0}}),
                                       1'b0, 1'b0);
      endcase
   end

   assign result = result_s;
   assign err    = err_s;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides: an input register,
// the combinational alu_core, and an output register holding result/flags/err.
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int NB_BITS = 8,
   parameter int NB_OPE  = 6
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [NB_BITS-1:0] i_dato_a,
   input  logic [NB_BITS-1:0] i_dato_b,
   input  logic [NB_OPE-1:0]  i_ope_sel,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [NB_BITS-1:0] o_result,
   output logic [3:0]         o_flags,
   output logic               o_err
);

   logic                      s1_valid_r;
   logic [NB_BITS-1:0]        s1_a_r;
   logic [NB_BITS-1:0]        s1_b_r;
   logic [NB_OPE-1:0]         s1_ope_r;

   logic                      s2_valid_r;
   logic [NB_BITS-1:0]        s2_result_r;
   logic [NB_FLAGS-1:0]       s2_flags_r;
   logic                      s2_err_r;

   logic                      s2_load_s;
   logic                      s1_advance_s;
   logic                      o_ready_s;
   logic [NB_BITS-1:0]        core_result_s;
   logic [NB_FLAGS-1:0]       core_flags_s;
   logic                      core_err_s;

   // Stage 2 frees up whenever it is empty or the sink takes its content;
   // that same event lets stage 1 move on, so i_ready reaches o_ready combinationally.
   assign s2_load_s    = !s2_valid_r || i_ready;
   assign s1_advance_s = s2_load_s;
   assign o_ready_s    = !s1_valid_r || s1_advance_s;

   alu_core #(
      .NB_BITS (NB_BITS)
   ) u_core (
      .a       (s1_a_r),
      .b       (s1_b_r),
      .ope_sel (s1_ope_r),
      .result  (core_result_s),
      .flags   (core_flags_s),
      .err     (core_err_s)
   );

   // Stage 1: input register, loaded on the upstream handshake.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         s1_valid_r <= 1'b0;
         s1_a_r     <= {NB_BITS{1'b0}};
         s1_b_r     <= {NB_BITS{1'b0}};
         s1_ope_r   <= {NB_OPE{1'b0}};
      end else if (o_ready_s) begin
         s1_valid_r <= i_valid;
         if (i_valid) begin
            s1_a_r   <= i_dato_a;
            s1_b_r   <= i_dato_b;
            s1_ope_r <= i_ope_sel;
         end
      end
   end

   // Stage 2: output register; payload only changes when a real op arrives,
   // so outputs stay frozen while the sink stalls.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         s2_valid_r  <= 1'b0;
         s2_result_r <= {NB_BITS{1'b0}};
         s2_flags_r  <= {NB_FLAGS{1'b0}};
         s2_err_r    <= 1'b0;
      end else if (s2_load_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_result_r <= core_result_s;
            s2_flags_r  <= core_flags_s;
            s2_err_r    <= core_err_s;
         end
      end
   end

   assign o_ready  = o_ready_s;
   assign o_valid  = s2_valid_r;
   assign o_result = s2_result_r;
   assign o_flags  = s2_flags_r;
   assign o_err    = s2_err_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: accepted ops push a model result, an output
// monitor pops and compares whenever the DUT hands a result to the sink.
module tb_alu_pipe;

   localparam int NB = 8;

   logic          clk = 1'b0;
   logic          i_reset;
   logic          i_valid;
   logic          o_ready;
   logic [NB-1:0] i_dato_a;
   logic [NB-1:0] i_dato_b;
   logic [5:0]    i_ope_sel;
   logic          o_valid;
   logic          i_ready;
   logic [NB-1:0] o_result;
   logic [3:0]    o_flags;
   logic          o_err;

   int checks   = 0;
   int failures = 0;
   int rdy_mode = 0;   // 0: always ready, 1: stalled, 2: random

   logic [NB+4:0] exp_q[$];
   logic [NB+4:0] mon_exp;
   logic [NB+4:0] mon_got;
   logic [NB+4:0] held_val;
   bit            held;

   always #5 clk = ~clk;

   alu_pipe #(.NB_BITS(NB), .NB_OPE(6)) dut (
      .i_clock   (clk),
      .i_reset   (i_reset),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_dato_a  (i_dato_a),
      .i_dato_b  (i_dato_b),
      .i_ope_sel (i_ope_sel),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_result  (o_result),
      .o_flags   (o_flags),
      .o_err     (o_err)
   );

   // Reference: {err, N, Z, C, V, result} from plain integer arithmetic.
   function automatic logic [NB+4:0] model(input int ua, input int ub, input logic [5:0] op);
      int m    = (1 << NB) - 1;
      int half = 1 << (NB - 1);
      int sa   = (ua >= half) ? ua - (1 << NB) : ua;
      int sb   = (ub >= half) ? ub - (1 << NB) : ub;
      int r    = 0;
      int t    = 0;
      bit c = 0, v = 0, e = 0, n, z;
      case (op)
         6'b100000: begin t = ua + ub; r = t & m; c = (t > m); t = sa + sb; v = (t >= half) || (t < -half); end
         6'b100010: begin r = (ua - ub) & m; c = (ua < ub); t = sa - sb; v = (t >= half) || (t < -half); end
         6'b100100: r = ua & ub;
         6'b100101: r = ua | ub;
         6'b100110: r = ua ^ ub;
         6'b100111: r = (~(ua | ub)) & m;
         6'b000000: r = (ub >= NB) ? 0 : ((ua << ub) & m);
         6'b000010: r = (ub >= NB) ? 0 : (ua >> ub);
         6'b000011: r = (ub >= NB) ? ((sa < 0) ? m : 0) : ((sa >>> ub) & m);
         6'b101010: r = (sa < sb) ? 1 : 0;
         6'b101011: r = (ua < ub) ? 1 : 0;
         default: begin e = 1; r = 0; end
      endcase
      n = ((r >> (NB - 1)) & 1) != 0;
      z = (r == 0);
      model = {e, n, z, c, v, r[NB-1:0]};
   endfunction

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   // Holds i_valid with one op until the DUT accepts it (bounded).
   task automatic send(input logic [5:0] op, input logic [NB-1:0] a, input logic [NB-1:0] b);
      bit ok = 0;
      i_valid   = 1'b1;
      i_ope_sel = op;
      i_dato_a  = a;
      i_dato_b  = b;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         ok = o_ready;
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: op %b not accepted within 50 cycles", op);
      end
   endtask

   // Sink readiness driver.
   initial begin
      i_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       i_ready = 1'b1;
            1:       i_ready = 1'b0;
            default: i_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Input monitor: every accepted op enqueues its expected response.
   initial forever begin
      @(negedge clk);
      if (i_reset && i_valid && o_ready)
         exp_q.push_back(model(int'(i_dato_a), int'(i_dato_b), i_ope_sel));
   end

   // Output monitor: compares transfers in order and checks stability under stall.
   initial begin
      held = 0;
      forever begin
         @(negedge clk);
         mon_got = {o_err, o_flags, o_result};
         if (!i_reset) begin
            held = 0;
         end else begin
            if (held) begin
               checks++;
               if (!o_valid || mon_got !== held_val) begin
                  failures++;
                  $display("FAIL hold_stable: got valid=%b out=%h, expected valid=1 out=%h", o_valid, mon_got, held_val);
               end
            end
            if (o_valid && i_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_output: got out=%h, expected no output", mon_got);
               end else begin
                  mon_exp = exp_q.pop_front();
                  if (mon_got !== mon_exp) begin
                     failures++;
                     $display("FAIL result: got err/flags/result=%h, expected %h", mon_got, mon_exp);
                  end
               end
               held = 0;
            end else if (o_valid) begin
               held     = 1;
               held_val = mon_got;
            end else begin
               held = 0;
            end
         end
      end
   end

   logic [5:0]    legal_ops[11] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                                    6'b000000, 6'b000010, 6'b000011, 6'b101010, 6'b101011};
   logic [5:0]    dir_op[14]    = '{6'b100000, 6'b100000, 6'b100010, 6'b100010, 6'b101010, 6'b101011, 6'b000011,
                                    6'b000011, 6'b000010, 6'b000000, 6'b111111, 6'b100100, 6'b100111, 6'b000000};
   logic [NB-1:0] dir_a[14]     = '{8'h7F, 8'hFF, 8'h00, 8'h80, 8'hFF, 8'hFF, 8'h80,
                                    8'h80, 8'h80, 8'h01, 8'h55, 8'hF0, 8'h0F, 8'hFF};
   logic [NB-1:0] dir_b[14]     = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h03,
                                    8'h09, 8'h09, 8'h07, 8'h00, 8'h3C, 8'hF0, 8'h08};

   initial begin
      i_reset   = 1'b0;
      i_valid   = 1'b0;
      i_dato_a  = 8'h00;
      i_dato_b  = 8'h00;
      i_ope_sel = 6'b000000;
      repeat (3) @(posedge clk);
      #1;
      i_reset = 1'b1;

      @(negedge clk);
      check("reset_o_valid", int'(o_valid), 0);
      check("reset_o_result", int'(o_result), 0);
      check("reset_o_flags", int'(o_flags), 0);
      check("reset_o_err", int'(o_err), 0);
      check("reset_o_ready", int'(o_ready), 1);

      // Latency: accepted at edge k, transferable just before edge k+2.
      @(posedge clk);
      #1;
      send(6'b100000, 8'h03, 8'h04);
      i_valid = 1'b0;
      @(negedge clk);
      check("latency_not_early", int'(o_valid), 0);
      @(negedge clk);
      check("latency_on_time", int'(o_valid), 1);
      check("latency_value", int'(o_result), 8'h07);
      @(posedge clk);
      #1;

      for (int i = 0; i < 14; i++) send(dir_op[i], dir_a[i], dir_b[i]);
      i_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Back-to-back stream with a three-cycle sink stall in the middle.
      fork
         begin
            for (int i = 1; i <= 10; i++) send(6'b100000, i[NB-1:0], 8'h01);
            i_valid = 1'b0;
         end
         begin
            repeat (4) @(posedge clk);
            rdy_mode = 1;
            repeat (3) begin
               @(negedge clk);
               check("stall_o_ready_low", int'(o_ready), 0);
               check("stall_o_valid_high", int'(o_valid), 1);
            end
            @(posedge clk);
            rdy_mode = 0;
         end
      join
      repeat (4) @(posedge clk);
      #1;

      // Reset with both stages full must discard everything.
      rdy_mode = 1;
      @(posedge clk);
      #1;
      send(6'b100000, 8'h11, 8'h22);
      send(6'b100110, 8'h33, 8'h44);
      i_valid = 1'b0;
      i_reset = 1'b0;
      @(posedge clk);
      #1;
      i_reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("midreset_o_valid", int'(o_valid), 0);
      check("midreset_o_result", int'(o_result), 0);
      check("midreset_o_flags", int'(o_flags), 0);
      check("midreset_o_err", int'(o_err), 0);
      check("midreset_o_ready", int'(o_ready), 1);
      rdy_mode = 0;
      repeat (4) @(posedge clk);
      #1;

      // Randomised traffic with random sink backpressure.
      rdy_mode = 2;
      for (int i = 0; i < 300; i++) begin
         logic [5:0]    op;
         logic [NB-1:0] a;
         logic [NB-1:0] b;
         op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : legal_ops[$urandom_range(0, 10)];
         a  = NB'($urandom);
         b  = ($urandom_range(0, 1) == 0) ? NB'($urandom_range(0, 15)) : NB'($urandom);
         send(op, a, b);
         if ($urandom_range(0, 4) == 0) begin
            i_valid = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      i_valid  = 1'b0;
      rdy_mode = 0;
      for (int t = 0; t < 40 && (exp_q.size() != 0 || o_valid); t++) @(posedge clk);
      @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
